// File: rtl/branch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_pkg: branch opcodes, flag layout, predictor reset value, cond_eval
// rev 1.0
// ----------------------------------------------------------------------------
package branch_pkg;

  localparam logic [4:0] c_opc_beq = 5'b10011;
  localparam logic [4:0] c_opc_blt = 5'b10100;
  localparam logic [4:0] c_opc_bgt = 5'b10101;
  localparam logic [4:0] c_opc_bne = 5'b10110;
  localparam logic [4:0] c_opc_ble = 5'b10111;
  localparam logic [4:0] c_opc_bge = 5'b11000;
  localparam logic [4:0] c_opc_bra = 5'b11001;

  // Bit positions within the 4-bit {Z,N,V,C} layout; wider/narrower flag
  // vectors keep Z at the MSB and are re-based by the user.
  localparam int c_flag_z = 3;
  localparam int c_flag_n = 2;
  localparam int c_flag_v = 1;
  localparam int c_flag_c = 0;

  localparam logic [1:0] c_ctr_rst = 2'b01;

  typedef struct packed {
    logic taken;
    logic is_branch;
  } cond_t;

  // znv = {Z,N,V}; carry never participates in a branch condition.
  function automatic cond_t cond_eval(input logic [4:0] opcode, input logic [2:0] znv);
    cond_t res;
    logic  z;
    logic  lt;
    z             = znv[2];
    lt            = znv[1] ^ znv[0];
    res.taken     = 1'b0;
    res.is_branch = 1'b1;
    case (opcode)
      c_opc_beq: res.taken = z;
      c_opc_bne: res.taken = !z;
      c_opc_blt: res.taken = lt;
      c_opc_bge: res.taken = !lt;
      c_opc_bgt: res.taken = !z && !lt;
      c_opc_ble: res.taken = z || lt;
      c_opc_bra: res.taken = 1'b1;
      default:   res.is_branch = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bht_2bit: table of 2-bit saturating direction counters, combinational read
// rev 1.0
// ----------------------------------------------------------------------------
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken
);

  logic [1:0] r_ctr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= c_ctr_rst;
    end else if (upd_en) begin
      if (upd_taken && (r_ctr[upd_idx] != 2'b11))
        r_ctr[upd_idx] <= r_ctr[upd_idx] + 2'd1;
      else if (!upd_taken && (r_ctr[upd_idx] != 2'b00))
        r_ctr[upd_idx] <= r_ctr[upd_idx] - 2'd1;
    end
  end

  // Reads see the stored value, so a same-cycle update shows up next cycle.
  assign rd_taken = r_ctr[rd_idx][1];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_resolve_unit: flag register + branch resolve; BHT when BRANCH_PREDICT_EN
// rev 1.0
// ----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int OPC_W     = 5,
  parameter int PC_W      = 16,
  parameter int FLAG_W    = 4,
  parameter int BHT_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              rs_valid,
  input  logic [OPC_W-1:0]  rs_opcode,
  input  logic [PC_W-1:0]   rs_pc,
  input  logic              rs_pred_taken,
  input  logic [PC_W-1:0]   pd_pc,
  output logic              pd_taken,
  output logic              br_taken,
  output logic              mispredict,
  output logic [FLAG_W-1:0] flags_q
);

  localparam int c_idx_w = $clog2(BHT_DEPTH);
  localparam int c_zi    = FLAG_W - 4 + c_flag_z;
  localparam int c_ni    = FLAG_W - 4 + c_flag_n;
  localparam int c_vi    = FLAG_W - 4 + c_flag_v;

  logic [FLAG_W-1:0]  r_flags;
  logic               r_br_taken;
  logic               r_mispredict;
  logic [FLAG_W-1:0]  w_eff_flags;
  logic [31:0]        w_opc_ext;
  cond_t              w_cond;
  logic               w_is_branch;
  logic               w_resolve;
  logic               w_mis_next;
  logic [c_idx_w-1:0] w_rs_idx;
  logic [c_idx_w-1:0] w_pd_idx;
  logic               w_unused;

  // ALU write-back in the same cycle bypasses the flag register.
  assign w_eff_flags = flag_we ? alu_flags : r_flags;
  assign w_opc_ext   = 32'(rs_opcode);
  assign w_cond      = cond_eval(w_opc_ext[4:0],
                                 {w_eff_flags[c_zi], w_eff_flags[c_ni], w_eff_flags[c_vi]});
  assign w_is_branch = w_cond.is_branch && (w_opc_ext[31:5] == '0);
  assign w_resolve   = rs_valid && !stall && w_is_branch;
  assign w_rs_idx    = rs_pc[c_idx_w-1:0];
  assign w_pd_idx    = pd_pc[c_idx_w-1:0];

`ifdef BRANCH_PREDICT_EN
  assign w_mis_next = w_cond.taken ^ rs_pred_taken;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (c_idx_w)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .upd_en    (w_resolve),
    .upd_idx   (w_rs_idx),
    .upd_taken (w_cond.taken),
    .rd_idx    (w_pd_idx),
    .rd_taken  (pd_taken)
  );

  assign w_unused = ^{w_eff_flags, rs_pc, pd_pc};
`else
  // Static not-taken: every taken branch is a mispredict.
  assign w_mis_next = w_cond.taken;
  assign pd_taken   = 1'b0;
  assign w_unused   = ^{w_eff_flags, rs_pc, pd_pc, rs_pred_taken, w_rs_idx, w_pd_idx, w_resolve};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags      <= '0;
      r_br_taken   <= 1'b0;
      r_mispredict <= 1'b0;
    end else if (!stall) begin
      if (flag_we) r_flags <= alu_flags;
      r_br_taken   <= rs_valid && w_is_branch && w_cond.taken;
      r_mispredict <= rs_valid && w_is_branch && w_mis_next;
    end
  end

  assign br_taken   = r_br_taken;
  assign mispredict = r_mispredict;
  assign flags_q    = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit: directed and random stimulus against a behavioural model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int OPC_W     = 5;
  localparam int PC_W      = 16;
  localparam int FLAG_W    = 4;
  localparam int BHT_DEPTH = 16;

`ifdef BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  localparam logic [4:0] BEQ = 5'h13, BLT = 5'h14, BNE = 5'h16, BRA = 5'h19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              flag_we = 1'b0;
  logic [FLAG_W-1:0] alu_flags = '0;
  logic              rs_valid = 1'b0;
  logic [OPC_W-1:0]  rs_opcode = '0;
  logic [PC_W-1:0]   rs_pc = '0;
  logic              rs_pred_taken = 1'b0;
  logic [PC_W-1:0]   pd_pc = '0;
  logic              pd_taken;
  logic              br_taken;
  logic              mispredict;
  logic [FLAG_W-1:0] flags_q;

  branch_resolve_unit #(
    .OPC_W(OPC_W), .PC_W(PC_W), .FLAG_W(FLAG_W), .BHT_DEPTH(BHT_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we), .alu_flags(alu_flags),
    .rs_valid(rs_valid), .rs_opcode(rs_opcode), .rs_pc(rs_pc),
    .rs_pred_taken(rs_pred_taken), .pd_pc(pd_pc), .pd_taken(pd_taken),
    .br_taken(br_taken), .mispredict(mispredict), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [3:0] m_flags;
  bit         m_br;
  bit         m_mis;
  int         m_ctr [BHT_DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Branch truth table written straight from the condition rules.
  function automatic bit ref_taken(input logic [4:0] opc, input logic [3:0] f, output bit is_br);
    bit z, lt;
    z     = f[3];
    lt    = (f[2] != f[1]);
    is_br = 1'b1;
    case (opc)
      5'h13:   return z;
      5'h16:   return !z;
      5'h14:   return lt;
      5'h18:   return !lt;
      5'h15:   return !z && !lt;
      5'h17:   return z || lt;
      5'h19:   return 1'b1;
      default: begin is_br = 1'b0; return 1'b0; end
    endcase
  endfunction

  function automatic logic exp_pd(input logic [15:0] pc);
    if (!PRED) return 1'b0;
    return m_ctr[int'(pc) % BHT_DEPTH] >= 2;
  endfunction

  task automatic model_reset();
    m_flags = '0;
    m_br    = 1'b0;
    m_mis   = 1'b0;
    for (int i = 0; i < BHT_DEPTH; i++) m_ctr[i] = 1;
  endtask

  task automatic model_step();
    logic [3:0] eff;
    bit t, isb;
    int idx;
    if (stall) return;
    eff = flag_we ? alu_flags : m_flags;
    t   = ref_taken(rs_opcode, eff, isb);
    if (flag_we) m_flags = alu_flags;
    if (rs_valid && isb) begin
      m_br  = t;
      m_mis = PRED ? (t ^ rs_pred_taken) : t;
      idx   = int'(rs_pc) % BHT_DEPTH;
      if (t) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
      else   m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    end else begin
      m_br  = 1'b0;
      m_mis = 1'b0;
    end
  endtask

  task automatic drive(input bit s, input bit fwe, input logic [3:0] af, input bit v,
                       input logic [4:0] opc, input logic [15:0] pc, input bit pt,
                       input logic [15:0] pdpc);
    stall = s; flag_we = fwe; alu_flags = af; rs_valid = v;
    rs_opcode = opc; rs_pc = pc; rs_pred_taken = pt; pd_pc = pdpc;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".br"},    32'(br_taken),   32'(m_br));
    check({tag, ".mis"},   32'(mispredict), 32'(m_mis));
    check({tag, ".flags"}, 32'(flags_q),    32'(m_flags));
    check({tag, ".pd"},    32'(pd_taken),   32'(exp_pd(pd_pc)));
  endtask

  // Inputs are driven 1 time unit after an edge; checks land before and after the next edge.
  task automatic cycle(input string tag);
    #1;
    check({tag, ".pd_pre"}, 32'(pd_taken), 32'(exp_pd(pd_pc)));
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive(0, 1, 4'b1000, 1, BEQ, 16'h0010, 0, 16'h0010);
    cycle("beq_z");
    check("beq_z.br_k",    32'(br_taken),   32'd1);
    check("beq_z.mis_k",   32'(mispredict), 32'd1);
    check("beq_z.flags_k", 32'(flags_q),    32'h8);

    drive(0, 1, 4'b0000, 0, BEQ, 16'h0020, 0, 16'h0020);
    cycle("clr_flags");
    drive(0, 1, 4'b0100, 1, BLT, 16'h0020, 1, 16'h0020);
    cycle("bypass");
    check("bypass.br_k",  32'(br_taken),   32'd1);
    check("bypass.mis_k", 32'(mispredict), PRED ? 32'd0 : 32'd1);

    for (int op = 0; op < 7; op++) begin
      for (int f = 0; f < 16; f++) begin
        drive(0, 1, 4'(f), 1, 5'(5'h13 + op), 16'($urandom), 1'($urandom), 16'($urandom));
        cycle($sformatf("sweep_op%0d_f%0d", op, f));
      end
    end
    drive(0, 1, 4'b1000, 1, 5'h01, 16'h0007, 1, 16'h0007);
    cycle("nonbranch");
    check("nonbranch.br_k",  32'(br_taken),   32'd0);
    check("nonbranch.mis_k", 32'(mispredict), 32'd0);

    // Load a pulse, then hit reset part-way through the next resolve.
    drive(0, 1, 4'b1010, 1, BRA, 16'h0003, 0, 16'h0003);
    cycle("pre_rst");
    drive(0, 0, 4'b0000, 1, BRA, 16'h0003, 0, 16'h0003);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst.br",    32'(br_taken),   32'd0);
    check("midrst.mis",   32'(mispredict), 32'd0);
    check("midrst.flags", 32'(flags_q),    32'd0);
    check("midrst.pd",    32'(pd_taken),   32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 4'b0000, 0, 5'h00, 16'h0000, 0, 16'h0003);
    rst = 1'b0;
    cycle("post_rst");
    check("post_rst.br_k", 32'(br_taken), 32'd0);

    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 4'b0000, 1, BRA, 16'h0003, 0, 16'h0003);
      #1;
      check($sformatf("sat_up%0d.pd_k", k), 32'(pd_taken), (PRED && k > 0) ? 32'd1 : 32'd0);
      cycle($sformatf("sat_up%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 4'b0000, 1, BEQ, 16'h0003, 0, 16'h0003);
      cycle($sformatf("sat_dn%0d", k));
    end
    #1;
    check("sat_dn.pd_k", 32'(pd_taken), 32'd0);

    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 4'b0000, 1, BRA, 16'h0005, 1, 16'h0005);
      cycle("alias_train");
    end
    drive(0, 0, 4'b0000, 0, 5'h00, 16'h0000, 0, 16'h0015);
    #1;
    check("alias.pd15_k", 32'(pd_taken), PRED ? 32'd1 : 32'd0);
    cycle("alias15");
    drive(0, 0, 4'b0000, 0, 5'h00, 16'h0000, 0, 16'h0006);
    cycle("alias06");
    check("alias.pd06_k", 32'(pd_taken), 32'd0);

    drive(0, 1, 4'b0000, 1, BNE, 16'h0005, 0, 16'h0005);
    cycle("pre_stall");
    drive(1, 1, 4'b1000, 1, BNE, 16'h0005, 1, 16'h0005);
    cycle("stall0");
    drive(1, 1, 4'b0000, 1, BEQ, 16'h0005, 0, 16'h0005);
    cycle("stall1");
    check("stall.br_k",    32'(br_taken), 32'd1);
    check("stall.flags_k", 32'(flags_q),  32'd0);
    drive(0, 0, 4'b0000, 0, BNE, 16'h0005, 0, 16'h0005);
    cycle("unstall");

    for (int n = 0; n < 300; n++) begin
      logic [15:0] pc;
      pc = 16'($urandom);
      drive(($urandom % 8) == 0, 1'($urandom), 4'($urandom), ($urandom % 4) != 0,
            (($urandom % 8) == 0) ? 5'($urandom) : 5'($urandom_range(16, 27)),
            pc, 1'($urandom), (($urandom % 2) == 0) ? pc : 16'($urandom));
      cycle($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
